// File: rtl/nios2_cpu_accel_sampler.sv
// nios2_cpu_accel_sampler
//
// Multi-channel accelerometer sampler on the Nios II Avalon-MM bus. On every
// accepted in_valid strobe, each of NUM_CH signed channels is added into its
// accumulator. After 2^AVG_LOG2 samples, the box average (arithmetic shift,
// rounding toward -inf) is latched into RESULT[i]. At the same time ready is
// raised (overrun too if ready was still pending), and the 16-bit frame
// counter advances. Software reads one averaged frame per interrupt instead of
// polling raw samples.
//
// Register map (word addresses):
//   0..3  RESULT[i]   sign-extended to 32 bits, 0 for i >= NUM_CH
//   4     STATUS      bit0 ready, bit1 overrun, write-1-to-clear
//   5     CONTROL     bit0 enable, bit1 irq_en, read-write
//   6     FRAME_COUNT 16 bits, zero-extended
//   7     reads 0
//
// Ports:
//   clk        single clock
//   reset      asynchronous, active-high
//   address    Avalon word address
//   write      Avalon write strobe
//   writedata  Avalon write data
//   in_port    channel samples, channel i at [i*DATA_W +: DATA_W]
//   in_valid   one-cycle sample strobe, qualifies in_port in the same cycle
//   readdata   registered read data (1-cycle latency, read strobe not needed)
//   irq        level interrupt, (ready | overrun) & irq_en, from registers only

module nios2_cpu_accel_sampler #(
    parameter int NUM_CH   = 3,
    parameter int DATA_W   = 16,
    parameter int AVG_LOG2 = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [2:0]               address,
    input  logic                     write,
    input  logic [31:0]              writedata,
    input  logic [NUM_CH*DATA_W-1:0] in_port,
    input  logic                     in_valid,
    output logic [31:0]              readdata,
    output logic                     irq
);

    // Accumulator is wide enough that 2^AVG_LOG2 full-scale samples cannot overflow.
    localparam int ACC_W = DATA_W + AVG_LOG2;
    // Keep the counter at least one bit wide so pass-through mode still elaborates.
    // With AVG_LOG2 = 0, LAST_CNT is 0, so every accepted sample ends a frame.
    localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << AVG_LOG2) - 1);

    localparam logic [2:0] ADDR_STATUS  = 3'd4;
    localparam logic [2:0] ADDR_CONTROL = 3'd5;
    localparam logic [2:0] ADDR_FRAME   = 3'd6;

    logic                     enable_q;
    logic                     irq_en_q;
    logic                     ready_q;
    logic                     overrun_q;
    logic [15:0]              frame_count_q;
    logic [CNT_W-1:0]         count_q;
    logic signed [ACC_W-1:0]  acc_q    [NUM_CH];
    logic signed [DATA_W-1:0] result_q [NUM_CH];

    logic                     ctrl_wr;
    logic                     status_wr;
    logic                     enable_next;
    logic                     sample_take;
    logic                     frame_done;
    logic signed [ACC_W-1:0]  sum_c    [NUM_CH];
    logic signed [DATA_W-1:0] avg_c    [NUM_CH];
    logic [31:0]              rd_mux;
    logic                     unused_wdata;

    assign ctrl_wr   = write && (address == ADDR_CONTROL);
    assign status_wr = write && (address == ADDR_STATUS);

    // Enable as it will be after this edge. A sample is only taken when the
    // block is enabled both before and after the edge. A CONTROL write that
    // disables the block discards the concurrent sample. A write that enables
    // the block does not accept a sample until the following strobe.
    assign enable_next = ctrl_wr ? writedata[0] : enable_q;
    assign sample_take = in_valid && enable_q && enable_next;
    assign frame_done  = sample_take && (count_q == LAST_CNT);

    assign unused_wdata = ^writedata[31:2];

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            sum_c[i] = acc_q[i] + ACC_W'(signed'(in_port[i*DATA_W +: DATA_W]));
            avg_c[i] = DATA_W'(sum_c[i] >>> AVG_LOG2);
        end
    end

    // Accumulators and sample counter. Both are held at zero while disabled,
    // so a disable drops any partial frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                acc_q[i] <= '0;
            end
        end else if (!enable_next || frame_done) begin
            count_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                acc_q[i] <= '0;
            end
        end else if (sample_take) begin
            count_q <= count_q + CNT_W'(1);
            for (int i = 0; i < NUM_CH; i++) begin
                acc_q[i] <= sum_c[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                result_q[i] <= '0;
            end
        end else if (frame_done) begin
            for (int i = 0; i < NUM_CH; i++) begin
                result_q[i] <= avg_c[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enable_q <= 1'b0;
            irq_en_q <= 1'b0;
        end else if (ctrl_wr) begin
            enable_q <= writedata[0];
            irq_en_q <= writedata[1];
        end
    end

    // A frame completion on the same edge as a W1C wins, so the set is OR-ed
    // after the clear. Overrun looks at ready as it was before this edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            ready_q   <= (ready_q & ~(status_wr & writedata[0])) | frame_done;
            overrun_q <= (overrun_q & ~(status_wr & writedata[1])) | (frame_done & ready_q);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_count_q <= '0;
        end else if (frame_done) begin
            frame_count_q <= frame_count_q + 16'd1;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_STATUS:  rd_mux = {30'd0, overrun_q, ready_q};
            ADDR_CONTROL: rd_mux = {30'd0, irq_en_q, enable_q};
            ADDR_FRAME:   rd_mux = {16'd0, frame_count_q};
            default: begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (address == 3'(i)) begin
                        rd_mux = 32'(result_q[i]);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata <= '0;
        end else begin
            readdata <= rd_mux;
        end
    end

    assign irq = (ready_q | overrun_q) & irq_en_q;

endmodule

// File: doc/nios2_cpu_accel_sampler.md
# nios2_cpu_accel_sampler

Parametrised multi-channel accelerometer sampler on the Nios II Avalon-MM bus. It succeeds the single-channel raw input PIO. It captures NUM_CH signed channels on a sample strobe and box-averages 2^AVG_LOG2 samples per channel into result registers. It also exposes ready/overrun status, a completed-frame counter and a maskable interrupt, so software reads one averaged frame instead of polling raw samples.

## Interface
Parameters:
- NUM_CH, 3: channel count, legal range 1..4.
- DATA_W, 16: signed sample width per channel, legal range 2..31.
- AVG_LOG2, 2: log2 of the averaging window, legal range 0..8. 0 means pass-through, one sample per frame.

Ports:
- clk  in  1: single clock for all logic.
- reset  in  1: asynchronous, active-high reset.
- address  in  3: Avalon word address.
- write  in  1: Avalon write strobe.
- writedata  in  32: write data.
- in_port  in  NUM_CH*DATA_W: channel samples, with channel i at bits [i*DATA_W +: DATA_W].
- in_valid  in  1: one-cycle strobe; in_port is valid in the same cycle.
- readdata  out  32: registered read data.
- irq  out  1: level interrupt.

## Operation
- Register map:
  - Addresses 0..3: RESULT[i], sign-extended to 32 bits. Addresses at or above NUM_CH read 0.
  - Address 4: STATUS, with bit0 = ready and bit1 = overrun.
  - Address 5: CONTROL, with bit0 = enable and bit1 = irq_en. Read-write.
  - Address 6: FRAME_COUNT, 16-bit, zero-extended.
  - Address 7: reads 0.
- Reads have no side effects. The read signal is not used.
- Writes:
  - STATUS is write-1-to-clear per bit.
  - CONTROL takes writedata[1:0].
  - Writes to other addresses are ignored.
- Accumulators: one per channel, DATA_W+AVG_LOG2 bits, signed, which cannot overflow.
- Sample counter: AVG_LOG2 bits.
- On in_valid while enable=1:
  - If it is not the last sample (count ≠ 2^AVG_LOG2−1): each accumulator adds its sign-extended sample, and count increments.
  - If it is the last sample:
    - RESULT[i] = (acc[i] + sample[i]) >>> AVG_LOG2. This is an arithmetic shift, truncating toward −∞.
    - Accumulators and count clear to 0.
    - FRAME_COUNT increments and wraps 0xFFFF→0.
    - ready is set. If ready was already 1 before this edge, overrun is also set.
- While enable=0:
  - in_valid is ignored.
  - Accumulators and count are held at 0.
  - RESULT, STATUS and FRAME_COUNT retain their values.
- irq = (ready | overrun) & irq_en. It is driven from registers only.
- Simultaneous events on one edge:
  - Frame completion plus a W1C of ready: set wins, so ready=1. The same rule applies to overrun.
  - A CONTROL write clearing enable plus in_valid: disable wins. The sample is discarded and the partial frame is dropped.
  - A CONTROL write setting enable plus in_valid: the sample is discarded. Accumulation starts on the next in_valid.
- Reset (at any time, including mid-frame) immediately forces to 0, without waiting for clk:
  - readdata
  - irq
  - RESULT
  - STATUS
  - CONTROL, so the block comes out of reset disabled
  - FRAME_COUNT
  - accumulators
  - count

## Timing
- readdata is registered every clk edge from the address mux, giving 1-cycle read latency. Address presented in cycle T appears on readdata in cycle T+1.
- Frame completion on edge E: RESULT/STATUS/irq change at E. A read addressed in the cycle after E returns the new value one cycle later.
- A W1C on edge E deasserts irq after E.
- Back-to-back in_valid on every cycle is supported. Max frame rate is clk / 2^AVG_LOG2.
- No combinational path from any input to any output.

## Test plan
- Reset: assert reset between edges → readdata=0 and irq=0 immediately. After release, CONTROL, STATUS and FRAME_COUNT read 0.
- Averaging (NUM_CH=3, DATA_W=16, AVG_LOG2=2): write CONTROL=3, then apply 4 in_valid pulses with:
  - x = 10, 20, 30, 40
  - y = −4, −4, −4, −8
  - z = 0x7FFF ×4
  
  Required response: RESULT0=25, RESULT1=0xFFFFFFFB (−5), RESULT2=0x00007FFF, STATUS=1, irq=1, FRAME_COUNT=1.
- Overrun/clear: complete a second frame without clearing → STATUS=3. Write STATUS=3 → STATUS=0, irq=0. Write CONTROL=1 and complete a frame → STATUS=1, irq=0.
- Simultaneous set/clear: W1C of STATUS=1 on the same edge as the 4th sample → STATUS reads 1 and irq stays 1.
- Disable mid-frame: apply 2 samples of 1000. Write CONTROL=0, then CONTROL=3. Then apply 4 samples of 100 → RESULT0=100, and FRAME_COUNT increments by exactly 1.
- Wrap/reset mid-frame:
  - Force 65536 frames with AVG_LOG2=0 → FRAME_COUNT=0.
  - Assert reset after 3 of 4 samples → all registers 0, and the next 4 samples produce a clean average.
